// File: rtl/dtc_apb_master.sv
// Purpose: converts a single valid/ready register command into an APB setup/access transfer and returns read data or a timeout error.
// Latency: 3 cycles from command acceptance to rsp_valid with no wait states, plus one cycle per pready=0 ACCESS cycle.
// Backpressure: one transfer outstanding; cmd_ready is low until the response has been consumed with rsp_ready.
module dtc_apb_master #(
    parameter int unsigned APB_AWIDTH = 32,
    parameter int unsigned APB_DWIDTH = 32,
    parameter int unsigned TIMEOUT    = 256
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [APB_AWIDTH-1:0] cmd_addr,
    input  logic [APB_DWIDTH-1:0] cmd_wdata,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [APB_DWIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,

    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [APB_AWIDTH-1:0] paddr,
    output logic [APB_DWIDTH-1:0] pwdata,
    input  logic                  pready,
    input  logic [APB_DWIDTH-1:0] prdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // A zero TIMEOUT disables the abort path; the counter then simply wraps.
    localparam bit          TMO_EN   = (TIMEOUT != 0);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t                r_state;
    state_t                w_next_state;

    logic                  r_write;
    logic [APB_AWIDTH-1:0] r_addr;
    logic [APB_DWIDTH-1:0] r_wdata;
    logic [15:0]           r_wait_cnt;
    logic [APB_DWIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;

    logic                  w_accept;
    logic                  w_tmo_hit;
    logic                  w_bus_active;

    assign w_accept     = (r_state == IDLE) && cmd_valid;
    assign w_bus_active = (r_state == SETUP) || (r_state == ACCESS);
    // Abort only when the completer is still stalling in the last allowed cycle.
    assign w_tmo_hit    = TMO_EN && (r_state == ACCESS) && !pready && (r_wait_cnt == TMO_LAST);

    // State register; reset drops any in-flight transfer without a response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode for the four-phase transfer sequence.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_next_state = SETUP;
                end
            end
            SETUP: begin
                w_next_state = ACCESS;
            end
            ACCESS: begin
                if (pready || w_tmo_hit) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Latch the command on acceptance; cmd_* is ignored in every other state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_write <= cmd_write;
            r_addr  <= cmd_addr;
            r_wdata <= cmd_wdata;
        end
    end

    // Wait-state counter: cleared on entry to SETUP, counts stalled ACCESS cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (w_accept) begin
            r_wait_cnt <= '0;
        end else if ((r_state == ACCESS) && !pready) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
        end
    end

    // Response capture; a ready completer beats a timeout in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (r_state == ACCESS) begin
            if (pready) begin
                r_rsp_rdata <= r_write ? '0 : prdata;
                r_rsp_err   <= 1'b0;
            end else if (w_tmo_hit) begin
                r_rsp_rdata <= '0;
                r_rsp_err   <= 1'b1;
            end
        end
    end

    // Handshake and APB outputs decode straight from the state register, so
    // an asynchronous reset returns every output to its idle value at once.
    assign cmd_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    assign psel      = w_bus_active;
    assign penable   = (r_state == ACCESS);
    assign pwrite    = w_bus_active && r_write;
    assign paddr     = w_bus_active ? r_addr : '0;
    assign pwdata    = (w_bus_active && r_write) ? r_wdata : '0;

endmodule
